// File: rtl/regfile_sb.sv
// Multi-port register file with write-first read bypass, a dedicated link
// write port and a per-register pending scoreboard for issue reservation.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int LINK_REG = (2**ADDR_W) - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     lnk_en,
    input  logic [DATA_W-1:0]        lnk_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ok,
    output logic [(2**ADDR_W)-1:0]   pend
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs   [NREG];
    logic [DATA_W-1:0] wd_vec [NREG];
    logic [NREG-1:0]   we_vec;
    logic [NREG-1:0]   clr_vec;
    logic [NREG-1:0]   set_vec;
    logic [ADDR_W-1:0] rd_ra  [N_RD];

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Per-register write decode; the link port is applied last so it wins.
    always_comb begin
        for (int a = 0; a < NREG; a++) begin
            we_vec[a]  = 1'b0;
            clr_vec[a] = 1'b0;
            wd_vec[a]  = '0;
            if (wr_en && (wr_addr == ADDR_W'(a))) begin
                we_vec[a]  = 1'b1;
                clr_vec[a] = 1'b1;
                wd_vec[a]  = wr_data;
            end
            if (lnk_en && (LINK_A == ADDR_W'(a))) begin
                we_vec[a]  = 1'b1;
                clr_vec[a] = 1'b1;
                wd_vec[a]  = lnk_data;
            end
            if (is_zero(ADDR_W'(a)))
                we_vec[a] = 1'b0;
        end
    end

    // Acceptance looks only at the registered pend, never at this cycle's clear.
    always_comb begin
        iss_ok  = iss_en && !pend[iss_addr] && !is_zero(iss_addr);
        set_vec = iss_ok ? (NREG'(1) << iss_addr) : '0;
    end

    always_comb begin
        for (int p = 0; p < N_RD; p++)
            rd_ra[p] = rd_addr[p*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NREG; a++)
                regs[a] <= '0;
            pend    <= '0;
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int a = 0; a < NREG; a++)
                if (we_vec[a])
                    regs[a] <= wd_vec[a];
            pend <= (pend & ~clr_vec) | set_vec;
            for (int p = 0; p < N_RD; p++) begin
                if (rd_en[p]) begin
                    if (is_zero(rd_ra[p]))
                        rd_data[p*DATA_W +: DATA_W] <= '0;
                    else if (we_vec[rd_ra[p]])
                        rd_data[p*DATA_W +: DATA_W] <= wd_vec[rd_ra[p]];
                    else
                        rd_data[p*DATA_W +: DATA_W] <= regs[rd_ra[p]];
                    rd_busy[p] <= pend[rd_ra[p]] & ~clr_vec[rd_ra[p]];
                end
            end
        end
    end

endmodule
